// File: rtl/preg_alloc_ctrl.sv
// Free-list port sequencer: arbitrates rename allocation against buffered commit frees,
// tracks free-register occupancy and drains returns on flush. Grant->tag latency 1 cycle.
module preg_alloc_ctrl #(
  parameter int PREG_WIDTH = 6,
  parameter int FL_DEPTH   = 32,
  parameter int RET_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req_in,
  output logic                  alloc_ready_out,
  output logic                  alloc_valid_out,
  output logic [PREG_WIDTH-1:0] alloc_preg_out,
  input  logic                  free_valid_in,
  input  logic [PREG_WIDTH-1:0] free_preg_in,
  output logic                  free_ready_out,
  input  logic                  flush_in,
  output logic                  busy_out,
  output logic                  overflow_err_out,
  output logic                  fl_dequeue_out,
  output logic                  fl_enqueue_out,
  output logic [PREG_WIDTH-1:0] fl_wdata_out,
  input  logic [PREG_WIDTH-1:0] fl_rdata_in
);

  localparam int CW  = $clog2(FL_DEPTH) + 1;
  localparam int PW  = $clog2(RET_DEPTH);
  localparam int RCW = PW + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         free_count_q, free_count_d;
  logic [RCW-1:0]        ret_count_q, ret_count_d;
  logic [PW-1:0]         ret_wr_q, ret_rd_q;
  logic [PREG_WIDTH-1:0] ret_mem_q [RET_DEPTH];
  logic                  alloc_valid_q, overflow_q;
  logic [PREG_WIDTH-1:0] alloc_preg_q;

  logic ret_full, ret_empty, fl_full, in_run;
  logic grant, pop, enq, push;

  assign ret_full  = (ret_count_q == RCW'(RET_DEPTH));
  assign ret_empty = (ret_count_q == '0);
  assign fl_full   = (free_count_q == CW'(FL_DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_in) state_d = DRAIN;
      DRAIN:   if (!flush_in && ret_empty && !free_valid_in) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output / arbitration logic; strobes held low while rst is asserted
  always_comb begin
    in_run          = (state_q == RUN);
    busy_out        = !rst && !in_run;
    free_ready_out  = !rst && !ret_full;
    alloc_ready_out = !rst && in_run && !flush_in && (free_count_q != '0) && !ret_full;
    grant           = alloc_req_in && alloc_ready_out;
    pop             = !rst && (ret_full || (!grant && !ret_empty));
    enq             = pop && !fl_full;
    push            = free_valid_in && free_ready_out;
    fl_dequeue_out  = grant;
    fl_enqueue_out  = enq;
    fl_wdata_out    = enq ? ret_mem_q[ret_rd_q] : '0;
  end

  always_comb begin
    free_count_d = free_count_q;
    if (grant)    free_count_d = free_count_q - CW'(1);
    else if (enq) free_count_d = free_count_q + CW'(1);
    ret_count_d = ret_count_q;
    if (push && !pop)      ret_count_d = ret_count_q + RCW'(1);
    else if (pop && !push) ret_count_d = ret_count_q - RCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_count_q  <= CW'(FL_DEPTH);
      ret_count_q   <= '0;
      ret_wr_q      <= '0;
      ret_rd_q      <= '0;
      alloc_valid_q <= 1'b0;
      alloc_preg_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      free_count_q  <= free_count_d;
      ret_count_q   <= ret_count_d;
      alloc_valid_q <= grant;
      if (push)  ret_wr_q     <= ret_wr_q + PW'(1);
      if (pop)   ret_rd_q     <= ret_rd_q + PW'(1);
      if (grant) alloc_preg_q <= fl_rdata_in;
      // A return into an already-full free list is dropped and flagged
      if (pop && fl_full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ret_mem_q[ret_wr_q] <= free_preg_in;
  end

  assign alloc_valid_out  = alloc_valid_q;
  assign alloc_preg_out   = alloc_preg_q;
  assign overflow_err_out = overflow_q;

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed bench for preg_alloc_ctrl with a behavioural circular free list.
module tb_preg_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req_in = 1'b0;
  logic       alloc_ready_out, alloc_valid_out;
  logic [5:0] alloc_preg_out;
  logic       free_valid_in = 1'b0;
  logic [5:0] free_preg_in = '0;
  logic       free_ready_out;
  logic       flush_in = 1'b0;
  logic       busy_out, overflow_err_out;
  logic       fl_dequeue_out, fl_enqueue_out;
  logic [5:0] fl_wdata_out, fl_rdata_in;

  int checks = 0;
  int failures = 0;

  preg_alloc_ctrl #(.PREG_WIDTH(6), .FL_DEPTH(32), .RET_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_in(alloc_req_in), .alloc_ready_out(alloc_ready_out),
    .alloc_valid_out(alloc_valid_out), .alloc_preg_out(alloc_preg_out),
    .free_valid_in(free_valid_in), .free_preg_in(free_preg_in),
    .free_ready_out(free_ready_out), .flush_in(flush_in),
    .busy_out(busy_out), .overflow_err_out(overflow_err_out),
    .fl_dequeue_out(fl_dequeue_out), .fl_enqueue_out(fl_enqueue_out),
    .fl_wdata_out(fl_wdata_out), .fl_rdata_in(fl_rdata_in)
  );

  always #5 clk = ~clk;

  // Free list: resets full with tags 32..63, head is combinational
  logic [5:0] fl_mem [32];
  logic [4:0] fl_rd, fl_wr;
  assign fl_rdata_in = fl_mem[fl_rd];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) fl_mem[i] <= 6'(32 + i);
      fl_rd <= '0;
      fl_wr <= '0;
    end else begin
      if (fl_dequeue_out) fl_rd <= fl_rd + 5'd1;
      if (fl_enqueue_out) begin
        fl_mem[fl_wr] <= fl_wdata_out;
        fl_wr <= fl_wr + 5'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", alloc_valid_out, 0);
    chk("rst_preg", alloc_preg_out, 0);
    chk("rst_ovf", overflow_err_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_enq", fl_enqueue_out, 0);
    chk("rst_deq", fl_dequeue_out, 0);
    chk("rst_free_ready", free_ready_out, 1);
    chk("rst_alloc_ready", alloc_ready_out, 1);
    chk("rst_free_count", dut.free_count_q, 32);
    chk("rst_ret_count", dut.ret_count_q, 0);

    // Exhaust the free list: tags 32..63, one per cycle
    alloc_req_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("t1_deq", fl_dequeue_out, 1);
      tick();
      chk("t1_valid", alloc_valid_out, 1);
      chk("t1_tag", alloc_preg_out, 32 + i);
    end
    #1;
    chk("t1_empty_ready", alloc_ready_out, 0);
    chk("t1_empty_deq", fl_dequeue_out, 0);
    chk("t1_busy", busy_out, 0);
    chk("t1_free_count", dut.free_count_q, 0);
    tick();
    chk("t1_no_valid", alloc_valid_out, 0);

    // Free tag 40 with the list empty: enqueue N+1, grant N+2, tag N+3
    free_valid_in = 1'b1;
    free_preg_in  = 6'd40;
    #1;
    chk("t2_ready_n", alloc_ready_out, 0);
    chk("t2_free_ready", free_ready_out, 1);
    chk("t2_no_bypass", fl_enqueue_out, 0);
    tick();
    free_valid_in = 1'b0;
    #1;
    chk("t2_enq", fl_enqueue_out, 1);
    chk("t2_wdata", fl_wdata_out, 40);
    chk("t2_deq_n1", fl_dequeue_out, 0);
    tick();
    #1;
    chk("t2_deq_n2", fl_dequeue_out, 1);
    tick();
    chk("t2_valid", alloc_valid_out, 1);
    chk("t2_tag", alloc_preg_out, 40);
    alloc_req_in = 1'b0;

    // Sustained alloc + free from a fresh reset fills the return buffer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alloc_req_in  = 1'b1;
    free_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      free_preg_in = 6'(10 + i);
      #1;
      chk("t3_ready", alloc_ready_out, 1);
      chk("t3_deq", fl_dequeue_out, 1);
      chk("t3_free_ready", free_ready_out, 1);
      tick();
      chk("t3_tag", alloc_preg_out, 32 + i);
    end
    free_preg_in = 6'd14;
    #1;
    chk("t3_full_ready", alloc_ready_out, 0);
    chk("t3_full_free_ready", free_ready_out, 0);
    chk("t3_full_deq", fl_dequeue_out, 0);
    chk("t3_full_enq", fl_enqueue_out, 1);
    chk("t3_full_wdata", fl_wdata_out, 10);
    tick();
    #1;
    chk("t3_gap_valid", alloc_valid_out, 0);
    chk("t3_resume", fl_dequeue_out, 1);
    chk("t3_resume_free_ready", free_ready_out, 1);
    tick();
    chk("t3_resume_tag", alloc_preg_out, 36);
    free_preg_in = 6'd15;
    #1;
    chk("t3_full2_wdata", fl_wdata_out, 11);
    chk("t3_full2_ready", alloc_ready_out, 0);
    tick();

    // Three tags (12,13,14) buffered; flush together with a request
    free_valid_in = 1'b0;
    flush_in = 1'b1;
    #1;
    chk("t4_flush_ready", alloc_ready_out, 0);
    chk("t4_flush_deq", fl_dequeue_out, 0);
    chk("t4_flush_wdata", fl_wdata_out, 12);
    chk("t4_flush_busy", busy_out, 0);
    tick();
    flush_in = 1'b0;
    #1;
    chk("t4_busy1", busy_out, 1);
    chk("t4_no_valid", alloc_valid_out, 0);
    chk("t4_drain_deq", fl_dequeue_out, 0);
    chk("t4_wdata2", fl_wdata_out, 13);
    tick();
    #1;
    chk("t4_wdata3", fl_wdata_out, 14);
    chk("t4_busy2", busy_out, 1);
    tick();
    #1;
    chk("t4_idle_enq", fl_enqueue_out, 0);
    chk("t4_busy3", busy_out, 1);
    chk("t4_drain_ready", alloc_ready_out, 0);
    tick();
    #1;
    chk("t4_run", busy_out, 0);
    chk("t4_run_deq", fl_dequeue_out, 1);
    tick();
    chk("t4_run_tag", alloc_preg_out, 37);
    alloc_req_in = 1'b0;

    // From reset the free list is full: a returned tag is discarded
    rst = 1'b1;
    tick();
    rst = 1'b0;
    free_valid_in = 1'b1;
    free_preg_in  = 6'd5;
    #1;
    chk("t5_free_ready", free_ready_out, 1);
    tick();
    free_valid_in = 1'b0;
    #1;
    chk("t5_no_enq", fl_enqueue_out, 0);
    chk("t5_wdata0", fl_wdata_out, 0);
    chk("t5_ovf_pre", overflow_err_out, 0);
    tick();
    chk("t5_ovf", overflow_err_out, 1);
    chk("t5_ret_count", dut.ret_count_q, 0);
    chk("t5_free_count", dut.free_count_q, 32);
    tick(); tick(); tick();
    chk("t5_ovf_sticky", overflow_err_out, 1);

    // Reset with two tags buffered
    alloc_req_in  = 1'b1;
    free_valid_in = 1'b1;
    free_preg_in  = 6'd20;
    tick();
    free_preg_in  = 6'd21;
    tick();
    chk("t6_buffered", dut.ret_count_q, 2);
    rst = 1'b1;
    alloc_req_in  = 1'b0;
    free_valid_in = 1'b0;
    #1;
    chk("t6_rst_enq", fl_enqueue_out, 0);
    chk("t6_rst_deq", fl_dequeue_out, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_free_count", dut.free_count_q, 32);
    chk("t6_ret_count", dut.ret_count_q, 0);
    chk("t6_busy", busy_out, 0);
    chk("t6_valid", alloc_valid_out, 0);
    chk("t6_preg", alloc_preg_out, 0);
    chk("t6_ovf", overflow_err_out, 0);
    chk("t6_enq", fl_enqueue_out, 0);
    chk("t6_wdata", fl_wdata_out, 0);
    alloc_req_in = 1'b1;
    #1;
    chk("t6_deq", fl_dequeue_out, 1);
    tick();
    alloc_req_in = 1'b0;
    chk("t6_tag_valid", alloc_valid_out, 1);
    chk("t6_tag", alloc_preg_out, 32);
    tick();
    chk("t6_pulse", alloc_valid_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/preg_alloc_ctrl.md
# preg_alloc_ctrl

Sequencing controller for the physical-register free list in the out-of-order core. It arbitrates the free list's single read/write port between rename allocation (dequeue) and ROB-commit frees (enqueue), and buffers commit frees so that none is dropped. It also tracks free-register occupancy and runs a flush-drain sequence so rename never allocates from a stale or contended free list.

## Interface
- PREG_WIDTH, 6: physical register tag width
- FL_DEPTH, 32: free-list capacity; free list resets holding tags FL_DEPTH..2*FL_DEPTH-1
- RET_DEPTH, 4: commit-return buffer depth (power of two)
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- alloc_req_in  in  1  rename requests one physical register
- alloc_ready_out  out  1  an allocation can be granted this cycle
- alloc_valid_out  out  1  alloc_preg_out holds a newly granted tag (one-cycle pulse)
- alloc_preg_out  out  PREG_WIDTH  granted tag
- free_valid_in  in  1  commit returns a tag
- free_preg_in  in  PREG_WIDTH  tag being returned
- free_ready_out  out  1  return buffer can accept a tag
- flush_in  in  1  pipeline flush pulse
- busy_out  out  1  controller is not in RUN
- overflow_err_out  out  1  sticky: enqueue attempted with the free list full
- fl_dequeue_out  out  1  free-list dequeue strobe
- fl_enqueue_out  out  1  free-list enqueue strobe
- fl_wdata_out  out  PREG_WIDTH  tag to enqueue
- fl_rdata_in  in  PREG_WIDTH  free-list head tag (combinational while fl_dequeue_out=1)

## Operation
- Registers:
  - free_count, width clog2(FL_DEPTH)+1, reset FL_DEPTH.
  - Return FIFO of RET_DEPTH entries with ret_count, reset 0.
  - State, reset RUN.
  - alloc_valid_out reset 0, alloc_preg_out reset 0, overflow_err_out reset 0.
- FSM states:
  - RUN: normal operation.
  - DRAIN: entered on flush_in. Allocation is blocked and return-buffer entries are enqueued. Exit to RUN when ret_count==0 and free_valid_in==0 in the same cycle.
  - flush_in while already in DRAIN keeps the FSM in DRAIN.
- Return buffer:
  - A push occurs when free_valid_in && free_ready_out.
  - free_ready_out = (ret_count != RET_DEPTH).
  - A push and a pop in the same cycle leave ret_count unchanged.
  - There is no bypass: a pushed tag reaches the free list one cycle later at the earliest.
- alloc_ready_out = (state==RUN) && !flush_in && (free_count != 0) && (ret_count != RET_DEPTH).
- Port arbitration (one free-list operation per cycle), first matching rule wins:
  1. ret_count==RET_DEPTH: enqueue the FIFO head.
  2. alloc_req_in && alloc_ready_out: dequeue (grant).
  3. ret_count != 0: enqueue the FIFO head.
  4. Otherwise: idle.
- fl_dequeue_out and fl_enqueue_out are never asserted together.
- Grant:
  - fl_dequeue_out=1.
  - fl_rdata_in is captured into alloc_preg_out.
  - free_count is decremented.
- Enqueue:
  - fl_enqueue_out=1, fl_wdata_out = FIFO head, FIFO pops.
  - free_count is incremented.
  - If free_count==FL_DEPTH: fl_enqueue_out stays 0, the entry is still popped and discarded, free_count is unchanged, and overflow_err_out is set. overflow_err_out clears only on rst.
- busy_out = (state != RUN).
- fl_wdata_out is 0 when fl_enqueue_out=0.

## Timing
- Grant in cycle N produces alloc_valid_out=1 with the tag in cycle N+1. alloc_valid_out is 0 otherwise, and back-to-back grants give one tag per cycle.
- Frees:
  - A free accepted in cycle N reaches the free list in cycle N+1 at the earliest, and later if allocations win the port.
  - Sustained alloc plus free traffic can fill the buffer. Rule 1 then forces an enqueue and alloc_ready_out drops for that cycle.
- flush_in in cycle N:
  - No grant occurs in cycle N; flush_in overrides a same-cycle request.
  - The state is DRAIN from N+1.
  - An enqueue in cycle N still occurs.
- free_count==0: alloc_ready_out=0. A tag freed in cycle N can be granted in cycle N+2 at the earliest.
- rst mid-operation: all registers return to reset values in the next cycle. Buffered tags are discarded because the free list also reinitialises. Outputs are 0 during and after rst until new traffic arrives.

## Test plan
- Reset, then assert alloc_req_in for 33 cycles:
  - Tags 32..63 are issued one per cycle from cycle 1.
  - alloc_ready_out=0 after the 32nd grant.
  - free_count=0; busy_out=0.
- With free_count=0, free tag 40 in cycle N with alloc_req_in held:
  - fl_enqueue_out in N+1.
  - Grant in N+2.
  - alloc_preg_out=40 in N+3.
- Hold alloc_req_in and free_valid_in continuously (tags 10, 11, 12, ...):
  - After 4 frees the buffer fills and alloc_ready_out drops for one cycle.
  - fl_enqueue_out with tag 10.
  - Granting then resumes.
- Fill the buffer with 3 tags, then pulse flush_in together with alloc_req_in:
  - No grant in the flush cycle.
  - busy_out=1.
  - 3 enqueues in order.
  - RUN when ret_count==0 and no free arrives.
- From reset (free_count=32), free tag 5:
  - Entry discarded, no fl_enqueue_out.
  - overflow_err_out=1 and remains set until rst.
- Assert rst mid-stream with 2 tags buffered:
  - Next cycle free_count=32, ret_count=0, RUN.
  - All outputs 0.
  - The next grant returns tag 32.
